// File: rtl/register_bank.sv
// General-purpose register bank: one write port, two combinational read ports and a
// handshaked dump sequencer. Optional same-cycle write forwarding via REGBANK_BYPASS_EN.
module register_bank #(
   parameter int B = 32,
   parameter int D = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         RegWrite,
   input  logic [D-1:0] write_addr,
   input  logic [B-1:0] write_data,
   input  logic [D-1:0] read_addr_a,
   input  logic [D-1:0] read_addr_b,
   output logic [B-1:0] data_a,
   output logic [B-1:0] data_b,
   input  logic         dump_start,
   input  logic         dump_ready,
   output logic         dump_valid,
   output logic [D-1:0] dump_addr,
   output logic [B-1:0] dump_data,
   output logic         dump_busy,
   output logic         dump_done
);

   localparam int N = 1 << D;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [B-1:0] r_regs [N];
   logic [1:0]   r_state;
   logic [D-1:0] r_dump_addr;
   logic [B-1:0] r_dump_data;

   logic         w_fwd_a;
   logic         w_fwd_b;
   logic         w_accept;
   logic         w_last;
   logic [D-1:0] w_next_addr;

   // Register 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) r_regs[i] <= '0;
      end else if (RegWrite && (write_addr != '0)) begin
         r_regs[write_addr] <= write_data;
      end
   end

`ifdef REGBANK_BYPASS_EN
   assign w_fwd_a = RegWrite && (write_addr != '0) && (write_addr == read_addr_a);
   assign w_fwd_b = RegWrite && (write_addr != '0) && (write_addr == read_addr_b);
`else
   assign w_fwd_a = 1'b0;
   assign w_fwd_b = 1'b0;
`endif

   assign data_a = (read_addr_a == '0) ? '0 : (w_fwd_a ? write_data : r_regs[read_addr_a]);
   assign data_b = (read_addr_b == '0) ? '0 : (w_fwd_b ? write_data : r_regs[read_addr_b]);

   assign dump_valid  = (r_state == S_SEND);
   assign dump_busy   = (r_state == S_SEND) || (r_state == S_DONE);
   assign dump_done   = (r_state == S_DONE);
   assign dump_addr   = r_dump_addr;
   assign dump_data   = r_dump_data;

   assign w_accept    = dump_valid && dump_ready;
   assign w_last      = &r_dump_addr;
   assign w_next_addr = r_dump_addr + 1'b1;

   // Beats sample r_regs before this edge's write lands, so each beat is a snapshot at load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_dump_addr <= '0;
         r_dump_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (dump_start) begin
                  r_state     <= S_SEND;
                  r_dump_addr <= '0;
                  r_dump_data <= r_regs[0];
               end
            end
            S_SEND: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_dump_addr <= w_next_addr;
                     r_dump_data <= r_regs[w_next_addr];
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: behavioural model compared every cycle plus
// directed vectors with literal expectations. Honours REGBANK_BYPASS_EN like the design.
module tb_register_bank;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [4:0]  read_addr_a;
   logic [4:0]  read_addr_b;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic        dump_start;
   logic        dump_ready;
   logic        dump_valid;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;
   logic        dump_busy;
   logic        dump_done;

   int n_checks = 0;
   int n_fail   = 0;

   register_bank #(.B(32), .D(5)) dut (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_addr(write_addr),
      .write_data(write_data), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
      .data_a(data_a), .data_b(data_b), .dump_start(dump_start), .dump_ready(dump_ready),
      .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
      .dump_busy(dump_busy), .dump_done(dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [31:0] m_regs [32];
   bit        m_busy;
   bit        m_valid;
   bit        m_done;
   int        m_addr;
   bit [31:0] m_data;

   function automatic bit [31:0] m_read(input int a);
      if (a == 0) return 32'h0;
`ifdef REGBANK_BYPASS_EN
      if (RegWrite === 1'b1 && write_addr != 5'd0 && int'(write_addr) == a) return write_data;
`endif
      return m_regs[a];
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_busy = 0; m_valid = 0; m_done = 0; m_addr = 0; m_data = '0;
      end else begin
         // dump progress uses register contents from before this cycle's write
         if (m_done) begin
            m_done = 0;
            m_busy = 0;
         end else if (m_valid && dump_ready) begin
            if (m_addr == 31) begin
               m_valid = 0;
               m_done  = 1;
            end else begin
               m_addr = m_addr + 1;
               m_data = m_regs[m_addr];
            end
         end else if (!m_busy && dump_start) begin
            m_busy  = 1;
            m_valid = 1;
            m_addr  = 0;
            m_data  = m_regs[0];
         end
         if (RegWrite && write_addr != 5'd0) m_regs[write_addr] = write_data;
      end
   end

   always @(negedge clk) begin
      chk("cmp_data_a",     data_a,            m_read(int'(read_addr_a)));
      chk("cmp_data_b",     data_b,            m_read(int'(read_addr_b)));
      chk("cmp_dump_valid", 32'(dump_valid),   32'(m_valid));
      chk("cmp_dump_busy",  32'(dump_busy),    32'(m_busy));
      chk("cmp_dump_done",  32'(dump_done),    32'(m_done));
      chk("cmp_dump_addr",  32'(dump_addr),    32'(m_addr));
      chk("cmp_dump_data",  dump_data,         m_data);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      int exp_idx;
      int done_at;
      bit got_done;

      reset = 1'b1; RegWrite = 0; write_addr = '0; write_data = '0;
      read_addr_a = '0; read_addr_b = '0; dump_start = 0; dump_ready = 0;
      #1 reset = 1'b0;
      repeat (2) tick();
      chk("rst_valid", 32'(dump_valid), 0);
      chk("rst_busy",  32'(dump_busy),  0);
      chk("rst_done",  32'(dump_done),  0);
      chk("rst_addr",  32'(dump_addr),  0);
      chk("rst_data",  dump_data,       0);
      reset = 1'b1;
      tick();

      // basic write/read, write to r0 discarded
      RegWrite = 1; write_addr = 5'd5; write_data = 32'hDEADBEEF; tick();
      write_addr = 5'd0; write_data = 32'h12345678; tick();
      RegWrite = 0; read_addr_a = 5'd5; read_addr_b = 5'd0; #1;
      chk("rd_r5", data_a, 32'hDEADBEEF);
      chk("rd_r0", data_b, 32'h0);
      tick();

      // same-cycle write vs read
      RegWrite = 1; write_addr = 5'd7; write_data = 32'hA5A5A5A5; read_addr_a = 5'd7; #1;
`ifdef REGBANK_BYPASS_EN
      chk("same_cycle_pre", data_a, 32'hA5A5A5A5);
`else
      chk("same_cycle_pre", data_a, 32'h0);
`endif
      tick();
      RegWrite = 0; #1;
      chk("same_cycle_post", data_a, 32'hA5A5A5A5);

      // load r1..r31 with index*0x11
      for (int i = 1; i < 32; i++) begin
         RegWrite = 1; write_addr = 5'(i); write_data = 32'(i * 32'h11); tick();
      end
      RegWrite = 0;

      // full dump, ready always high
      dump_ready = 1; dump_start = 1; tick(); dump_start = 0;
      for (int k = 0; k < 32; k++) begin
         chk("full_valid", 32'(dump_valid), 1);
         chk("full_addr",  32'(dump_addr),  32'(k));
         chk("full_data",  dump_data,       32'(k * 32'h11));
         tick();
      end
      chk("full_done_pulse", 32'(dump_done),  1);
      chk("full_valid_off",  32'(dump_valid), 0);
      tick();
      chk("full_done_clear", 32'(dump_done), 0);
      chk("full_busy_clear", 32'(dump_busy), 0);

      // dump with ready toggling 1,0,0,1
      dump_start = 1; tick(); dump_start = 0;
      exp_idx = 0; got_done = 0;
      for (int c = 0; c < 200; c++) begin
         dump_ready = pat[c % 4]; #1;
         if (dump_done) begin
            chk("tog_done_after_last", 32'(exp_idx), 32);
            got_done = 1;
            break;
         end
         if (dump_valid && dump_ready) begin
            chk("tog_addr", 32'(dump_addr), 32'(exp_idx));
            chk("tog_data", dump_data, 32'(exp_idx * 32'h11));
            exp_idx++;
         end
         tick();
      end
      chk("tog_done_seen", 32'(got_done), 1);
      dump_ready = 1;
      tick();

      // writes and a second dump_start while a dump is running
      dump_start = 1; tick(); dump_start = 0;
      done_at = -1;
      for (int c = 0; c < 40; c++) begin
         RegWrite = 0; dump_start = 0;
         if (dump_done) begin
            done_at = c;
            break;
         end
         if (dump_valid) begin
            chk("mid_addr", 32'(dump_addr), 32'(c));
            chk("mid_data", dump_data, (dump_addr == 5'd20) ? 32'h0BADF00D : 32'(c * 32'h11));
            if (dump_addr == 5'd10) begin
               RegWrite = 1; write_addr = 5'd3; write_data = 32'hFFFFFFFF; dump_start = 1;
            end
            if (dump_addr == 5'd11) begin
               RegWrite = 1; write_addr = 5'd20; write_data = 32'h0BADF00D; dump_start = 1;
            end
         end
         tick();
      end
      RegWrite = 0; dump_start = 0;
      chk("mid_done_cycle", 32'(done_at), 32);
      tick();
      chk("mid_idle_busy", 32'(dump_busy), 0);
      tick();
      chk("mid_idle_valid", 32'(dump_valid), 0);
      read_addr_a = 5'd3; read_addr_b = 5'd20; #1;
      chk("mid_r3", data_a, 32'hFFFFFFFF);
      chk("mid_r20", data_b, 32'h0BADF00D);

      // reset in the middle of a dump
      dump_start = 1; tick(); dump_start = 0;
      for (int c = 0; c < 12; c++) tick();
      chk("pre_rst_addr", 32'(dump_addr), 12);
      reset = 1'b0; #1;
      chk("mrst_valid", 32'(dump_valid), 0);
      chk("mrst_busy",  32'(dump_busy),  0);
      chk("mrst_done",  32'(dump_done),  0);
      chk("mrst_addr",  32'(dump_addr),  0);
      chk("mrst_data",  dump_data,       0);
      for (int i = 0; i < 32; i++) begin
         read_addr_a = 5'(i); read_addr_b = 5'(31 - i); #1;
         chk("mrst_read_a", data_a, 0);
         chk("mrst_read_b", data_b, 0);
      end
      tick();
      reset = 1'b1;
      tick();
      dump_start = 1; tick(); dump_start = 0;
      chk("restart_valid", 32'(dump_valid), 1);
      chk("restart_addr",  32'(dump_addr),  0);
      chk("restart_data",  dump_data,       0);
      repeat (34) tick();
      chk("restart_idle", 32'(dump_busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
